// File: rtl/red_pitaya_sort_pulser.sv
// Sort-trigger to electrode-drive pulser: delay, gated square-wave burst, dead time.
// Optional macro SORT_PULSER_BIPOLAR_EN alternates burst polarity on each accepted trigger.
module red_pitaya_sort_pulser #(
    parameter int DW = 14,
    parameter int TW = 32,
    parameter int PW = 16,
    parameter int NW = 8
) (
    input  logic                 adc_clk_i,
    input  logic                 adc_rst_i,
    input  logic                 enable_i,
    input  logic                 sort_trig_i,
    input  logic [TW-1:0]        cfg_delay_i,
    input  logic [PW-1:0]        cfg_half_i,
    input  logic [NW-1:0]        cfg_nhalf_i,
    input  logic [TW-1:0]        cfg_dead_i,
    input  logic signed [DW-1:0] cfg_amp_i,
    input  logic                 clr_cnt_i,
    output logic signed [DW-1:0] dac_o,
    output logic                 pulse_o,
    output logic                 busy_o,
    output logic [31:0]          sorted_cnt_o,
    output logic [31:0]          missed_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_PULSE = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    localparam logic [31:0]          CNT_MAX = 32'hFFFF_FFFF;
    localparam logic signed [DW-1:0] AMP_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] AMP_MAX = {1'b0, {(DW-1){1'b1}}};

    state_t                state_q, state_d;
    logic                  trig_q;
    logic                  edge_q;
    logic [TW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         half_q, half_d;
    logic [NW-1:0]         idx_q, idx_d;
    logic signed [DW-1:0]  amp_q, amp_d;
    logic [PW-1:0]         halfcfg_q, halfcfg_d;
    logic [NW-1:0]         nhalf_q, nhalf_d;
    logic [TW-1:0]         dead_q, dead_d;
    logic signed [DW-1:0]  dac_q, dac_d;
    logic                  pulse_q, pulse_d;
    logic [31:0]           sorted_q, sorted_d;
    logic [31:0]           missed_q, missed_d;
    logic                  inv_w;

    logic                  accept;
    logic                  missed_hit;
    logic [PW-1:0]         half_load;
    logic [TW-1:0]         dead_load;
    logic signed [DW-1:0]  amp_neg;

`ifdef SORT_PULSER_BIPOLAR_EN
    logic pol_q, pol_d;
    logic inv_q, inv_d;
    assign inv_w = inv_q;
`else
    assign inv_w = 1'b0;
`endif

    assign accept     = edge_q & enable_i & (state_q == S_IDLE);
    assign missed_hit = edge_q & (state_q != S_IDLE);
    // A zero half-period behaves as one cycle; dead time of zero still spends one cycle in DEAD.
    assign half_load  = (halfcfg_q == '0) ? '0 : halfcfg_q - PW'(1);
    assign dead_load  = (dead_q == '0) ? '0 : dead_q - TW'(1);
    assign amp_neg    = (amp_q == AMP_MIN) ? AMP_MAX : -amp_q;

    // State and datapath registers
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            state_q   <= S_IDLE;
            trig_q    <= 1'b0;
            edge_q    <= 1'b0;
            cnt_q     <= '0;
            half_q    <= '0;
            idx_q     <= '0;
            amp_q     <= '0;
            halfcfg_q <= '0;
            nhalf_q   <= '0;
            dead_q    <= '0;
            dac_q     <= '0;
            pulse_q   <= 1'b0;
            sorted_q  <= '0;
            missed_q  <= '0;
`ifdef SORT_PULSER_BIPOLAR_EN
            pol_q     <= 1'b0;
            inv_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            trig_q    <= sort_trig_i;
            edge_q    <= sort_trig_i & ~trig_q;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            idx_q     <= idx_d;
            amp_q     <= amp_d;
            halfcfg_q <= halfcfg_d;
            nhalf_q   <= nhalf_d;
            dead_q    <= dead_d;
            dac_q     <= dac_d;
            pulse_q   <= pulse_d;
            sorted_q  <= sorted_d;
            missed_q  <= missed_d;
`ifdef SORT_PULSER_BIPOLAR_EN
            pol_q     <= pol_d;
            inv_q     <= inv_d;
`endif
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        half_d    = half_q;
        idx_d     = idx_q;
        amp_d     = amp_q;
        halfcfg_d = halfcfg_q;
        nhalf_d   = nhalf_q;
        dead_d    = dead_q;
`ifdef SORT_PULSER_BIPOLAR_EN
        pol_d     = pol_q;
        inv_d     = inv_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_DELAY;
                    cnt_d     = cfg_delay_i;
                    amp_d     = cfg_amp_i;
                    halfcfg_d = cfg_half_i;
                    nhalf_d   = cfg_nhalf_i;
                    dead_d    = cfg_dead_i;
`ifdef SORT_PULSER_BIPOLAR_EN
                    inv_d     = pol_q;
                    pol_d     = ~pol_q;
`endif
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    if (nhalf_q == '0) begin
                        state_d = S_DEAD;
                        cnt_d   = dead_load;
                    end else begin
                        state_d = S_PULSE;
                        half_d  = half_load;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            S_PULSE: begin
                if (half_q == '0) begin
                    if (idx_q == nhalf_q - NW'(1)) begin
                        state_d = S_DEAD;
                        cnt_d   = dead_load;
                    end else begin
                        idx_d  = idx_q + NW'(1);
                        half_d = half_load;
                    end
                end else begin
                    half_d = half_q - PW'(1);
                end
            end
            S_DEAD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Clear has priority over a coincident increment
        sorted_d = sorted_q;
        missed_d = missed_q;
        if (clr_cnt_i) begin
            sorted_d = '0;
            missed_d = '0;
        end else begin
            if (accept && (sorted_q != CNT_MAX)) sorted_d = sorted_q + 32'd1;
            if (missed_hit && (missed_q != CNT_MAX)) missed_d = missed_q + 32'd1;
        end
    end

    // Registered outputs follow the state being entered
    always_comb begin
        pulse_d = (state_d == S_PULSE);
        dac_d   = '0;
        if (pulse_d) begin
            dac_d = (idx_d[0] ^ inv_w) ? amp_neg : amp_q;
        end
    end

    assign dac_o        = dac_q;
    assign pulse_o      = pulse_q;
    assign busy_o       = (state_q != S_IDLE);
    assign sorted_cnt_o = sorted_q;
    assign missed_cnt_o = missed_q;

endmodule

// File: tb/tb_red_pitaya_sort_pulser.sv
// Bench for red_pitaya_sort_pulser: waveform-level reference model plus literal checks.
module tb_red_pitaya_sort_pulser;

    localparam int DW = 14;
    localparam int TW = 32;
    localparam int PW = 16;
    localparam int NW = 8;
    localparam longint MAXC = 64'hFFFF_FFFF;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 en = 1'b1;
    logic                 trig = 1'b0;
    logic                 clr = 1'b0;
    logic [TW-1:0]        cfg_delay = '0;
    logic [PW-1:0]        cfg_half = '0;
    logic [NW-1:0]        cfg_nhalf = '0;
    logic [TW-1:0]        cfg_dead = '0;
    logic signed [DW-1:0] cfg_amp = '0;
    logic signed [DW-1:0] dac_o;
    logic                 pulse_o;
    logic                 busy_o;
    logic [31:0]          sorted_cnt_o;
    logic [31:0]          missed_cnt_o;

    red_pitaya_sort_pulser #(.DW(DW), .TW(TW), .PW(PW), .NW(NW)) dut (
        .adc_clk_i    (clk),
        .adc_rst_i    (rst),
        .enable_i     (en),
        .sort_trig_i  (trig),
        .cfg_delay_i  (cfg_delay),
        .cfg_half_i   (cfg_half),
        .cfg_nhalf_i  (cfg_nhalf),
        .cfg_dead_i   (cfg_dead),
        .cfg_amp_i    (cfg_amp),
        .clr_cnt_i    (clr),
        .dac_o        (dac_o),
        .pulse_o      (pulse_o),
        .busy_o       (busy_o),
        .sorted_cnt_o (sorted_cnt_o),
        .missed_cnt_o (missed_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Expected {busy, pulse, dac} per upcoming clock edge
    logic [DW+1:0] exp_q[$];
    longint m_sorted = 0;
    longint m_missed = 0;
    logic   m_prev = 1'b0;
    logic   m_pend = 1'b0;
    logic   m_busy = 1'b0;
`ifdef SORT_PULSER_BIPOLAR_EN
    logic   m_pol = 1'b0;
`endif

    int got_q[$];
    int lit_q[$];
    int first_pulse_cyc = -1;
    int last_pulse_cyc = -1;
    int fall_cyc = -1;
    int trig_cyc = 0;
    logic busy_prev = 1'b0;

    task automatic chk(input string nm, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
        end
    endtask

    // Whole burst from the rules: delay+1 idle-busy cycles, nhalf half-periods, max(dead,1) dead cycles
    task automatic push_burst();
        int h;
        int a;
        int na;
        int v;
        logic inv;
        logic [DW-1:0] vb;
        h   = (cfg_half == 0) ? 1 : int'(cfg_half);
        a   = int'(cfg_amp);
        na  = (a == -(1 << (DW - 1))) ? ((1 << (DW - 1)) - 1) : -a;
        inv = 1'b0;
`ifdef SORT_PULSER_BIPOLAR_EN
        inv   = m_pol;
        m_pol = ~m_pol;
`endif
        for (int i = 0; i <= int'(cfg_delay); i++) exp_q.push_back({1'b1, 1'b0, {DW{1'b0}}});
        for (int j = 0; j < int'(cfg_nhalf); j++) begin
            v  = (((j % 2) == 1) ^ inv) ? na : a;
            vb = DW'(v);
            for (int k = 0; k < h; k++) exp_q.push_back({1'b1, 1'b1, vb});
        end
        for (int i = 0; i < ((cfg_dead == 0) ? 1 : int'(cfg_dead)); i++)
            exp_q.push_back({1'b1, 1'b0, {DW{1'b0}}});
    endtask

    // One clock: drive, advance the model for this edge, compare every output
    task automatic step(input logic t);
        logic [DW+1:0] cur;
        trig = t;
        @(posedge clk);
        #1;
        cyc++;
        cur = '0;
        if (rst) begin
            exp_q.delete();
            m_sorted = 0;
            m_missed = 0;
            m_prev   = 1'b0;
            m_pend   = 1'b0;
`ifdef SORT_PULSER_BIPOLAR_EN
            m_pol    = 1'b0;
`endif
        end else begin
            if (m_pend) begin
                if (m_busy) begin
                    if (m_missed < MAXC) m_missed++;
                end else if (en) begin
                    if (m_sorted < MAXC) m_sorted++;
                    push_burst();
                end
            end
            if (clr) begin
                m_sorted = 0;
                m_missed = 0;
            end
            m_pend = t & ~m_prev;
            m_prev = t;
            if (exp_q.size() > 0) cur = exp_q.pop_front();
        end
        m_busy = cur[DW+1];
        chk("dac", longint'(dac_o), longint'($signed(cur[DW-1:0])));
        chk("pulse", longint'(pulse_o), longint'(cur[DW]));
        chk("busy", longint'(busy_o), longint'(cur[DW+1]));
        chk("sorted", longint'(sorted_cnt_o), m_sorted);
        chk("missed", longint'(missed_cnt_o), m_missed);
        if (pulse_o) begin
            got_q.push_back(int'(dac_o));
            if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
            last_pulse_cyc = cyc;
        end
        if (busy_prev && !busy_o) fall_cyc = cyc;
        busy_prev = busy_o;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        got_q.delete();
        first_pulse_cyc = -1;
        last_pulse_cyc  = -1;
        fall_cyc        = -1;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic check_lit(input string nm);
        chk({nm, "_len"}, got_q.size(), lit_q.size());
        for (int i = 0; i < lit_q.size() && i < got_q.size(); i++)
            chk(nm, got_q[i], lit_q[i]);
    endtask

    task automatic set_cfg(input int d, input int h, input int n, input int dd, input int a);
        cfg_delay = TW'(d);
        cfg_half  = PW'(h);
        cfg_nhalf = NW'(n);
        cfg_dead  = TW'(dd);
        cfg_amp   = DW'(a);
    endtask

    initial begin
        // Basic burst and latency
        do_reset();
        chk("rst_dac", longint'(dac_o), 0);
        chk("rst_busy", longint'(busy_o), 0);
        set_cfg(3, 2, 4, 5, 1000);
        step(1'b1);
        trig_cyc = cyc;
        step(1'b1);
        run_idle(30);
        lit_q = '{1000, 1000, -1000, -1000, 1000, 1000, -1000, -1000};
        check_lit("t1_seq");
        chk("t1_latency", first_pulse_cyc - trig_cyc, 5);
        chk("t1_idle_after", fall_cyc - last_pulse_cyc, 6);
        chk("t1_sorted", longint'(sorted_cnt_o), 1);
        chk("t1_missed", longint'(missed_cnt_o), 0);

        // Edges during DELAY and DEAD are missed, burst unchanged
        do_reset();
        set_cfg(6, 2, 4, 5, 1000);
        for (int i = 0; i < 40; i++) step((i == 0) || (i == 3) || (i == 18));
        check_lit("t2_seq");
        chk("t2_sorted", longint'(sorted_cnt_o), 1);
        chk("t2_missed", longint'(missed_cnt_o), 2);

        // Level held high counts once
        do_reset();
        set_cfg(3, 2, 4, 5, 1000);
        for (int i = 0; i < 100; i++) step(1'b1);
        run_idle(20);
        chk("t3_sorted", longint'(sorted_cnt_o), 1);
        chk("t3_missed", longint'(missed_cnt_o), 0);
        chk("t3_samples", got_q.size(), 8);

        // Saturating negation of the most negative amplitude
        do_reset();
        set_cfg(0, 1, 2, 0, -8192);
        step(1'b1);
        run_idle(10);
        lit_q = '{-8192, 8191};
        check_lit("t4_seq");

        // Reset during the third pulse sample, then a fresh burst
        do_reset();
        set_cfg(3, 2, 4, 5, 1000);
        for (int i = 0; i < 40 && got_q.size() < 3; i++) step(i == 0);
        chk("t5_reached", got_q.size(), 3);
        rst = 1'b1;
        step(1'b0);
        chk("t5_dac", longint'(dac_o), 0);
        chk("t5_pulse", longint'(pulse_o), 0);
        chk("t5_busy", longint'(busy_o), 0);
        chk("t5_sorted", longint'(sorted_cnt_o), 0);
        rst = 1'b0;
        got_q.delete();
        step(1'b1);
        run_idle(30);
        lit_q = '{1000, 1000, -1000, -1000, 1000, 1000, -1000, -1000};
        check_lit("t5_seq");

        // Two separated bursts: polarity alternation only with the macro
        do_reset();
        set_cfg(1, 1, 2, 1, 500);
        step(1'b1);
        run_idle(15);
        step(1'b1);
        run_idle(15);
`ifdef SORT_PULSER_BIPOLAR_EN
        lit_q = '{500, -500, -500, 500};
`else
        lit_q = '{500, -500, 500, -500};
`endif
        check_lit("t6_seq");
        chk("t6_sorted", longint'(sorted_cnt_o), 2);

        // half=0, enable dropped mid-burst, disabled trigger, nhalf=0, clear coinciding with accept
        do_reset();
        set_cfg(2, 0, 3, 0, 77);
        step(1'b1);
        step(1'b0);
        en = 1'b0;
        run_idle(12);
        step(1'b1);
        run_idle(5);
        lit_q = '{77, -77, 77};
        check_lit("t7_seq");
        chk("t7_sorted", longint'(sorted_cnt_o), 1);
        en = 1'b1;
        set_cfg(1, 3, 0, 2, 300);
        step(1'b1);
        run_idle(10);
        chk("t7_nhalf0_samples", got_q.size(), 3);
        chk("t7_sorted2", longint'(sorted_cnt_o), 2);
        step(1'b1);
        clr = 1'b1;
        step(1'b0);
        clr = 1'b0;
        run_idle(10);
        chk("t7_clr_wins", longint'(sorted_cnt_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
